// File: rtl/nasti_dm_pkg.sv
// Shared definitions for the NASTI data mover engine.
// Holds the controller state encoding, the NASTI burst/response codes
// used on the bus, and the 4 KB page size that bursts must not cross.
package nasti_dm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        FINISH
    } state_t;

    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [12:0] PAGE_BYTES = 13'd4096;

endpackage

// File: rtl/nasti_dm_buffer.sv
// Burst buffer for the data mover: a synchronous FIFO holding one read burst
// until it is written back out.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   clr           synchronous flush (drops any stored beats)
//   push, wdata   write one beat (ignored when full)
//   pop, rdata    rdata shows the oldest beat; pop removes it (ignored when empty)
//   empty, full   occupancy flags
module nasti_dm_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    // Pointers wrap explicitly so DEPTH need not fill the pointer range.
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        if (p == IW'(DEPTH - 1)) begin
            return '0;
        end
        return p + IW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/nasti_data_mover_engine.sv
// NASTI data mover engine. On dm_en in IDLE it copies `length` bytes from
// src_addr to dest_addr, one store-and-forward burst at a time: read a burst
// into the internal buffer, write it back out, wait for the write response,
// repeat. Bursts are limited by remaining beats, MAX_BURST and the 4 KB page
// of both source and destination.
// Ports:
//   aclk, areset             clock, asynchronous active-high reset
//   src_addr/dest_addr/length transfer description, latched at start
//   dm_en                    start request (only honoured in IDLE)
//   done                     1 = idle, 0 = transfer in progress
//   error                    sticky bus error flag for the last transfer
//   ar_* / r_*               NASTI read address / read data channels
//   aw_* / w_* / b_*         NASTI write address / data / response channels
module nasti_data_mover_engine
    import nasti_dm_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [ADDR_WIDTH-1:0]   dest_addr,
    input  logic [ADDR_WIDTH-1:0]   length,
    input  logic                    dm_en,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_WIDTH-1:0]   ar_addr,
    output logic [7:0]              ar_len,
    output logic [2:0]              ar_size,
    output logic [1:0]              ar_burst,
    output logic                    ar_valid,
    input  logic                    ar_ready,
    input  logic [DATA_WIDTH-1:0]   r_data,
    input  logic [1:0]              r_resp,
    input  logic                    r_last,
    input  logic                    r_valid,
    output logic                    r_ready,
    output logic [ADDR_WIDTH-1:0]   aw_addr,
    output logic [7:0]              aw_len,
    output logic [2:0]              aw_size,
    output logic [1:0]              aw_burst,
    output logic                    aw_valid,
    input  logic                    aw_ready,
    output logic [DATA_WIDTH-1:0]   w_data,
    output logic [DATA_WIDTH/8-1:0] w_strb,
    output logic                    w_last,
    output logic                    w_valid,
    input  logic                    w_ready,
    input  logic [1:0]              b_resp,
    input  logic                    b_valid,
    output logic                    b_ready
);

    localparam int BPB = DATA_WIDTH / 8;
    localparam int LB  = $clog2(BPB);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'(BPB - 1);

    // Beats allowed in the next burst, given the page offsets of both
    // addresses and the beats still to move.
    function automatic logic [12:0] burst_beats(input logic [11:0]           s_off,
                                                input logic [11:0]           d_off,
                                                input logic [ADDR_WIDTH-1:0] rem);
        logic [12:0] s_room;
        logic [12:0] d_room;
        logic [12:0] n;
        s_room = (PAGE_BYTES - {1'b0, s_off}) >> LB;
        d_room = (PAGE_BYTES - {1'b0, d_off}) >> LB;
        n = 13'(MAX_BURST);
        if (s_room < n) n = s_room;
        if (d_room < n) n = d_room;
        if (rem < ADDR_WIDTH'(n)) n = rem[12:0];
        return n;
    endfunction

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   src_q, src_d, dst_q, dst_d, rem_q, rem_d;
    logic [8:0]              beats_q, beats_d, rcnt_q, rcnt_d, wcnt_q, wcnt_d;
    logic                    error_q, error_d, done_q, done_d;
    logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
    logic [7:0]              ar_len_q, ar_len_d, aw_len_q, aw_len_d;
    logic                    ar_valid_q, ar_valid_d, aw_valid_q, aw_valid_d;
    logic                    r_ready_q, r_ready_d, b_ready_q, b_ready_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic                    w_last_q, w_last_d, w_valid_q, w_valid_d;

    logic [ADDR_WIDTH-1:0]   src_al, dst_al, len_beats, step;
    logic [ADDR_WIDTH-1:0]   src_nx, dst_nx, rem_nx;
    logic [ADDR_WIDTH-1:0]   plan_src, plan_dst, plan_rem;
    logic [8:0]              nb;
    logic                    buf_push, buf_pop, buf_clr, buf_empty, buf_full;
    logic [DATA_WIDTH-1:0]   buf_rdata;
    logic                    r_hs, r_bad, w_fire, w_load;

    nasti_dm_buffer #(
        .DEPTH (MAX_BURST),
        .WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk   (aclk),
        .rst   (areset),
        .clr   (buf_clr),
        .push  (buf_push),
        .wdata (r_data),
        .pop   (buf_pop),
        .rdata (buf_rdata),
        .empty (buf_empty),
        .full  (buf_full)
    );

    assign src_al    = src_addr & ~BEAT_MASK;
    assign dst_al    = dest_addr & ~BEAT_MASK;
    assign len_beats = length >> LB;
    assign step      = ADDR_WIDTH'(beats_q) << LB;
    assign src_nx    = src_q + step;
    assign dst_nx    = dst_q + step;
    assign rem_nx    = rem_q - ADDR_WIDTH'(beats_q);

    // One sizing path serves both the first burst (from the inputs) and the
    // following ones (from the advanced pointers after a write response).
    assign plan_src  = (state_q == IDLE) ? src_al    : src_nx;
    assign plan_dst  = (state_q == IDLE) ? dst_al    : dst_nx;
    assign plan_rem  = (state_q == IDLE) ? len_beats : rem_nx;
    assign nb        = 9'(burst_beats(plan_src[11:0], plan_dst[11:0], plan_rem));

    assign r_hs      = (state_q == RD_DATA) && r_valid && r_ready_q;
    assign r_bad     = r_hs && (r_resp != RESP_OKAY);
    // Beats beyond buffer depth are dropped; r_last still ends the burst.
    assign buf_push  = r_hs && !buf_full;
    assign w_fire    = w_valid_q && w_ready;
    // W output register refills from the buffer whenever it is free.
    assign w_load    = (state_q == WR_DATA) && !buf_empty && (!w_valid_q || w_fire);
    assign buf_pop   = w_load;
    assign buf_clr   = (state_q == FINISH);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        beats_d    = beats_q;
        rcnt_d     = rcnt_q;
        wcnt_d     = wcnt_q;
        error_d    = error_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_valid_d = ar_valid_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_valid_d = aw_valid_q;
        r_ready_d  = r_ready_q;
        b_ready_d  = b_ready_q;
        w_data_d   = w_data_q;
        w_last_d   = w_last_q;
        w_valid_d  = w_valid_q;

        if (w_load) begin
            w_valid_d = 1'b1;
            w_data_d  = buf_rdata;
            w_last_d  = (wcnt_q == rcnt_q - 9'd1);
            wcnt_d    = wcnt_q + 9'd1;
        end else if (w_fire) begin
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (dm_en) begin
                    src_d   = src_al;
                    dst_d   = dst_al;
                    rem_d   = len_beats;
                    error_d = 1'b0;
                    if (len_beats == '0) begin
                        state_d = FINISH;
                    end else begin
                        ar_addr_d  = src_al;
                        ar_len_d   = 8'(nb - 9'd1);
                        ar_valid_d = 1'b1;
                        beats_d    = nb;
                        rcnt_d     = '0;
                        state_d    = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RD_DATA;
                end
            end
            RD_DATA: begin
                if (buf_push) begin
                    rcnt_d = rcnt_q + 9'd1;
                end
                if (r_bad) begin
                    error_d = 1'b1;
                end
                if (r_hs && r_last) begin
                    r_ready_d = 1'b0;
                    // error_q can only have been set by this read burst.
                    if (error_q || r_bad) begin
                        state_d = FINISH;
                    end else begin
                        aw_addr_d  = dst_q;
                        aw_len_d   = 8'(rcnt_q + {8'd0, buf_push} - 9'd1);
                        aw_valid_d = 1'b1;
                        state_d    = WR_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                if (aw_ready) begin
                    aw_valid_d = 1'b0;
                    wcnt_d     = '0;
                    state_d    = WR_DATA;
                end
            end
            WR_DATA: begin
                if (w_fire && w_last_q) begin
                    b_ready_d = 1'b1;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_valid) begin
                    b_ready_d = 1'b0;
                    if (b_resp != RESP_OKAY) begin
                        error_d = 1'b1;
                        state_d = FINISH;
                    end else begin
                        src_d = src_nx;
                        dst_d = dst_nx;
                        rem_d = rem_nx;
                        if (rem_nx == '0) begin
                            state_d = FINISH;
                        end else begin
                            ar_addr_d  = src_nx;
                            ar_len_d   = 8'(nb - 9'd1);
                            ar_valid_d = 1'b1;
                            beats_d    = nb;
                            rcnt_d     = '0;
                            state_d    = RD_ADDR;
                        end
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == IDLE);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            beats_q    <= '0;
            rcnt_q     <= '0;
            wcnt_q     <= '0;
            error_q    <= 1'b0;
            done_q     <= 1'b1;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            w_data_q   <= '0;
            w_last_q   <= 1'b0;
            w_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rem_q      <= rem_d;
            beats_q    <= beats_d;
            rcnt_q     <= rcnt_d;
            wcnt_q     <= wcnt_d;
            error_q    <= error_d;
            done_q     <= done_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_valid_q <= ar_valid_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_valid_q <= aw_valid_d;
            r_ready_q  <= r_ready_d;
            b_ready_q  <= b_ready_d;
            w_data_q   <= w_data_d;
            w_last_q   <= w_last_d;
            w_valid_q  <= w_valid_d;
        end
    end

    assign done     = done_q;
    assign error    = error_q;
    assign ar_addr  = ar_addr_q;
    assign ar_len   = ar_len_q;
    assign ar_size  = 3'(LB);
    assign ar_burst = BURST_INCR;
    assign ar_valid = ar_valid_q;
    assign r_ready  = r_ready_q;
    assign aw_addr  = aw_addr_q;
    assign aw_len   = aw_len_q;
    assign aw_size  = 3'(LB);
    assign aw_burst = BURST_INCR;
    assign aw_valid = aw_valid_q;
    assign w_data   = w_data_q;
    assign w_strb   = '1;
    assign w_last   = w_last_q;
    assign w_valid  = w_valid_q;
    assign b_ready  = b_ready_q;

endmodule

// File: tb/tb_nasti_data_mover_engine.sv
module tb_nasti_data_mover_engine;

    logic        aclk = 1'b0;
    logic        areset;
    logic [63:0] src_addr, dest_addr, length;
    logic        dm_en;
    logic        done, error;
    logic [63:0] ar_addr, aw_addr;
    logic [7:0]  ar_len, aw_len;
    logic [2:0]  ar_size, aw_size;
    logic [1:0]  ar_burst, aw_burst;
    logic        ar_valid, ar_ready, aw_valid, aw_ready;
    logic [63:0] r_data, w_data;
    logic [1:0]  r_resp, b_resp;
    logic        r_last, r_valid, r_ready;
    logic [7:0]  w_strb;
    logic        w_last, w_valid, w_ready;
    logic        b_valid, b_ready;

    nasti_data_mover_engine #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64),
        .MAX_BURST  (16)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .src_addr  (src_addr),
        .dest_addr (dest_addr),
        .length    (length),
        .dm_en     (dm_en),
        .done      (done),
        .error     (error),
        .ar_addr   (ar_addr),
        .ar_len    (ar_len),
        .ar_size   (ar_size),
        .ar_burst  (ar_burst),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .r_data    (r_data),
        .r_resp    (r_resp),
        .r_last    (r_last),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .aw_addr   (aw_addr),
        .aw_len    (aw_len),
        .aw_size   (aw_size),
        .aw_burst  (aw_burst),
        .aw_valid  (aw_valid),
        .aw_ready  (aw_ready),
        .w_data    (w_data),
        .w_strb    (w_strb),
        .w_last    (w_last),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .b_resp    (b_resp),
        .b_valid   (b_valid),
        .b_ready   (b_ready)
    );

    always #5 aclk = ~aclk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [63:0] addr;
        int unsigned len;
    } burst_t;

    burst_t      exp_ar[$], exp_aw[$];
    burst_t      rq[$], awq[$];
    logic [63:0] dmem [logic [63:0]];
    int          ar_cnt, aw_cnt, b_cnt, bpend;
    int unsigned rbeat, wbeat;
    int          rburst_idx;
    int          err_burst = -1;
    int unsigned err_beat  = 0;
    logic        b_err = 1'b0;
    logic        stall = 1'b0;

    function automatic logic [63:0] sdata(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0] + 32'h1234_5678};
    endfunction

    // Burst plan straight from the sizing rule: min(remaining, 16, room to
    // the next 4 KB page of source, same for destination).
    task automatic plan(input logic [63:0] s0, input logic [63:0] d0, input logic [63:0] len0);
        logic [63:0] s, d, rem, b, rs, rd;
        burst_t bt;
        exp_ar.delete();
        exp_aw.delete();
        s   = s0 & ~64'h7;
        d   = d0 & ~64'h7;
        rem = len0 >> 3;
        while (rem != 0) begin
            b  = 16;
            if (rem < b) b = rem;
            rs = (4096 - (s % 4096)) / 8;
            rd = (4096 - (d % 4096)) / 8;
            if (rs < b) b = rs;
            if (rd < b) b = rd;
            bt.len  = 32'(b - 1);
            bt.addr = s;
            exp_ar.push_back(bt);
            bt.addr = d;
            exp_aw.push_back(bt);
            s   = s + b * 8;
            d   = d + b * 8;
            rem = rem - b;
        end
    endtask

    // Slave + monitor. Each falling edge processes the handshakes of the
    // rising edge just passed (from the snapshot taken one falling edge
    // earlier), then drives the next inputs and snapshots again.
    logic        p_ar_v, p_ar_r, p_aw_v, p_aw_r, p_r_v, p_r_r, p_r_last;
    logic        p_w_v, p_w_r, p_w_last, p_b_v, p_b_r;
    logic [63:0] p_ar_addr, p_aw_addr, p_w_data;
    logic [7:0]  p_ar_len, p_aw_len, p_w_strb;
    logic [2:0]  p_ar_size, p_aw_size;
    logic [1:0]  p_ar_burst, p_aw_burst;

    task automatic clear_snapshot();
        p_ar_v = 0; p_ar_r = 0; p_aw_v = 0; p_aw_r = 0; p_r_v = 0; p_r_r = 0;
        p_r_last = 0; p_w_v = 0; p_w_r = 0; p_w_last = 0; p_b_v = 0; p_b_r = 0;
    endtask

    initial begin
        burst_t bt;
        ar_ready = 0; aw_ready = 0; w_ready = 0;
        r_valid = 0; r_last = 0; r_resp = 0; r_data = 0;
        b_valid = 0; b_resp = 0;
        clear_snapshot();
        forever begin
            @(negedge aclk);
            if (areset) begin
                rq.delete(); awq.delete();
                rbeat = 0; wbeat = 0; bpend = 0; rburst_idx = 0;
                ar_ready = 0; aw_ready = 0; w_ready = 0;
                r_valid = 0; r_last = 0; r_resp = 0;
                b_valid = 0; b_resp = 0;
                clear_snapshot();
                continue;
            end
            if (p_ar_v && p_ar_r) begin
                if (ar_cnt < exp_ar.size()) begin
                    check("ar_addr", p_ar_addr, exp_ar[ar_cnt].addr);
                    check("ar_len", 64'(p_ar_len), 64'(exp_ar[ar_cnt].len));
                end else begin
                    check("ar_unexpected", 1, 0);
                end
                check("ar_size", 64'(p_ar_size), 3);
                check("ar_burst", 64'(p_ar_burst), 1);
                bt.addr = p_ar_addr;
                bt.len  = 32'(p_ar_len);
                rq.push_back(bt);
                ar_cnt++;
            end
            if (p_ar_v && !p_ar_r)
                check("ar_hold", ar_valid && ar_addr == p_ar_addr && ar_len == p_ar_len, 1);
            if (p_r_v && p_r_r && rq.size() > 0) begin
                if (p_r_last) begin
                    void'(rq.pop_front());
                    rbeat = 0;
                    rburst_idx++;
                end else begin
                    rbeat++;
                end
            end
            if (p_aw_v && p_aw_r) begin
                if (aw_cnt < exp_aw.size()) begin
                    check("aw_addr", p_aw_addr, exp_aw[aw_cnt].addr);
                    check("aw_len", 64'(p_aw_len), 64'(exp_aw[aw_cnt].len));
                end else begin
                    check("aw_unexpected", 1, 0);
                end
                check("aw_size", 64'(p_aw_size), 3);
                check("aw_burst", 64'(p_aw_burst), 1);
                bt.addr = p_aw_addr;
                bt.len  = 32'(p_aw_len);
                awq.push_back(bt);
                aw_cnt++;
            end
            if (p_aw_v && !p_aw_r)
                check("aw_hold", aw_valid && aw_addr == p_aw_addr && aw_len == p_aw_len, 1);
            if (p_w_v && p_w_r) begin
                if (awq.size() == 0) begin
                    check("w_before_aw", 1, 0);
                end else begin
                    dmem[awq[0].addr + 64'(wbeat) * 8] = p_w_data;
                    check("w_last", 64'(p_w_last), 64'(wbeat == awq[0].len));
                    check("w_strb", 64'(p_w_strb), 64'hFF);
                    if (wbeat == awq[0].len) begin
                        void'(awq.pop_front());
                        wbeat = 0;
                        bpend++;
                    end else begin
                        wbeat++;
                    end
                end
            end
            if (p_b_v && p_b_r) begin
                bpend--;
                b_cnt++;
            end
            if (ar_valid || aw_valid || w_valid)
                check("done_while_busy", 64'(done), 0);

            ar_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            aw_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            w_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (r_valid && !p_r_r) begin
                // hold the pending beat
            end else if (rq.size() > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
                r_valid = 1;
                r_data  = sdata(rq[0].addr + 64'(rbeat) * 8);
                r_last  = (rbeat == rq[0].len);
                r_resp  = (rburst_idx == err_burst && rbeat == err_beat) ? 2'b10 : 2'b00;
            end else begin
                r_valid = 0;
                r_last  = 0;
                r_resp  = 0;
            end
            if (b_valid && !p_b_r) begin
                // hold the pending response
            end else if (bpend > 0 && (!stall || $urandom_range(0, 1) != 0)) begin
                b_valid = 1;
                b_resp  = b_err ? 2'b10 : 2'b00;
            end else begin
                b_valid = 0;
                b_resp  = 0;
            end

            p_ar_v = ar_valid; p_ar_r = ar_ready; p_ar_addr = ar_addr; p_ar_len = ar_len;
            p_ar_size = ar_size; p_ar_burst = ar_burst;
            p_aw_v = aw_valid; p_aw_r = aw_ready; p_aw_addr = aw_addr; p_aw_len = aw_len;
            p_aw_size = aw_size; p_aw_burst = aw_burst;
            p_r_v = r_valid; p_r_r = r_ready; p_r_last = r_last;
            p_w_v = w_valid; p_w_r = w_ready; p_w_data = w_data; p_w_last = w_last; p_w_strb = w_strb;
            p_b_v = b_valid; p_b_r = b_ready;
        end
    end

    task automatic kick(input logic [63:0] s, input logic [63:0] d, input logic [63:0] len);
        ar_cnt = 0; aw_cnt = 0; b_cnt = 0; rburst_idx = 0;
        dmem.delete();
        @(negedge aclk);
        src_addr = s; dest_addr = d; length = len; dm_en = 1;
        @(negedge aclk);
        dm_en = 0;
        check("start_done_low", 64'(done), 0);
        check("start_error_clear", 64'(error), 0);
    endtask

    // Runs one transfer; err_b >= 0 injects SLVERR on beat err_bt of read
    // burst err_b, berr makes the first write response SLVERR.
    task automatic run_xfer(input logic [63:0] s, input logic [63:0] d, input logic [63:0] len,
                            input int err_b, input int unsigned err_bt, input logic berr,
                            input logic stl, output int busy);
        logic exp_err;
        logic [63:0] a;
        plan(s, d, len);
        exp_err = 0;
        if (err_b >= 0) begin
            while (exp_ar.size() > err_b + 1) void'(exp_ar.pop_back());
            while (exp_aw.size() > err_b) void'(exp_aw.pop_back());
            exp_err = 1;
        end else if (berr) begin
            while (exp_ar.size() > 1) void'(exp_ar.pop_back());
            while (exp_aw.size() > 1) void'(exp_aw.pop_back());
            exp_err = 1;
        end
        err_burst = err_b; err_beat = err_bt; b_err = berr; stall = stl;
        kick(s, d, len);
        busy = 0;
        while (!done && busy < 5000) begin
            busy++;
            @(negedge aclk);
        end
        if (!done) check("done_timeout", 0, 1);
        check("ar_count", 64'(ar_cnt), 64'(exp_ar.size()));
        check("aw_count", 64'(aw_cnt), 64'(exp_aw.size()));
        check("b_count", 64'(b_cnt), 64'(exp_aw.size()));
        check("error_flag", 64'(error), 64'(exp_err));
        for (int k = 0; k < exp_aw.size(); k++) begin
            for (int unsigned i = 0; i <= exp_aw[k].len; i++) begin
                a = exp_aw[k].addr + 64'(i) * 8;
                check("dest_data", dmem.exists(a) ? dmem[a] : 64'bx,
                      sdata(exp_ar[k].addr + 64'(i) * 8));
            end
        end
        err_burst = -1; b_err = 0; stall = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int waitc;
        areset = 1; dm_en = 0; src_addr = 0; dest_addr = 0; length = 0;
        ar_cnt = 0; aw_cnt = 0; b_cnt = 0;
        repeat (3) @(negedge aclk);
        check("rst_done", 64'(done), 1);
        check("rst_error", 64'(error), 0);
        check("rst_valids", {61'd0, ar_valid, aw_valid, w_valid}, 0);
        check("rst_readies", {62'd0, r_ready, b_ready}, 0);
        check("rst_ar_addr", ar_addr, 0);
        areset = 0;
        repeat (2) @(negedge aclk);
        check("idle_done", 64'(done), 1);

        // Zero-beat length: exactly one busy cycle, no bus traffic.
        run_xfer(64'h40, 64'h80, 64'd4, -1, 0, 0, 0, busy);
        check("zero_len_busy_cycles", 64'(busy), 1);

        plan(64'h1000, 64'h2000, 64'd64);
        check("model_single_count", 64'(exp_ar.size()), 1);
        check("model_single_len", 64'(exp_ar[0].len), 7);
        run_xfer(64'h1000, 64'h2000, 64'd64, -1, 0, 0, 0, busy);

        plan(64'h1000, 64'h3000, 64'd320);
        check("model_320_count", 64'(exp_ar.size()), 3);
        check("model_320_len0", 64'(exp_ar[0].len), 15);
        check("model_320_len2", 64'(exp_ar[2].len), 7);
        check("model_320_step", exp_ar[1].addr, 64'h1080);
        run_xfer(64'h1000, 64'h3000, 64'd320, -1, 0, 0, 1, busy);

        plan(64'h0FC0, 64'h5000, 64'd256);
        check("model_page_count", 64'(exp_ar.size()), 3);
        check("model_page_len0", 64'(exp_ar[0].len), 7);
        check("model_page_len1", 64'(exp_ar[1].len), 15);
        check("model_page_addr1", exp_ar[1].addr, 64'h1000);
        run_xfer(64'h0FC0, 64'h5000, 64'd256, -1, 0, 0, 1, busy);

        // Read error on beat 3 of the first burst, then a clean transfer.
        run_xfer(64'h1000, 64'h2000, 64'd320, 0, 3, 0, 0, busy);
        run_xfer(64'h1000, 64'h2000, 64'd64, -1, 0, 0, 0, busy);
        // Write response error ends the transfer after the first burst.
        run_xfer(64'h1000, 64'h2000, 64'd320, -1, 0, 1, 1, busy);

        for (int t = 0; t < 6; t++) begin
            logic [63:0] rs, rd, rl;
            rs = 64'($urandom_range(0, 32'h3FFF));
            rd = 64'($urandom_range(32'h8000, 32'hBFFF));
            rl = 64'($urandom_range(0, 900));
            run_xfer(rs, rd, rl, -1, 0, 0, 1'($urandom_range(0, 1)), busy);
        end

        // Asynchronous reset in the middle of the write phase.
        plan(64'h1000, 64'h2000, 64'd320);
        stall = 1;
        kick(64'h1000, 64'h2000, 64'd320);
        waitc = 0;
        while (!w_valid && waitc < 2000) begin
            waitc++;
            @(negedge aclk);
        end
        check("reached_wr_data", 64'(w_valid), 1);
        #2 areset = 1;
        #1;
        check("async_rst_valids", {61'd0, ar_valid, aw_valid, w_valid}, 0);
        check("async_rst_readies", {62'd0, r_ready, b_ready}, 0);
        check("async_rst_done", 64'(done), 1);
        repeat (2) @(negedge aclk);
        areset = 0;
        stall = 0;
        repeat (2) @(negedge aclk);
        run_xfer(64'h0FC0, 64'h6000, 64'd256, -1, 0, 0, 1, busy);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
